// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, FSM state and width constants shared by alu_pipe
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_PASS_A0 = 3'b000,
    OP_PASS_A1 = 3'b001,
    OP_ADD     = 3'b010,
    OP_AND     = 3'b011,
    OP_XOR     = 3'b100,
    OP_PASS_B  = 3'b101,
    OP_MUL     = 3'b110,
    OP_SHR     = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  // Only the multiply leaves IDLE; every other opcode completes in one cycle.
  function automatic logic is_multi_cycle(alu_op_e op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product,
  output logic             o_overflow
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_next;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  // done is raised during the last step so the caller can capture the result
  // on the same edge that completes the final partial-product add.
  assign o_done     = r_busy && (r_cnt == LAST);
  assign o_product  = w_acc_next[WIDTH-1:0];
  assign o_overflow = |w_acc_next[2*WIDTH-1:WIDTH];

  // Load operands on start, then step WIDTH times; reset drops any partial product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered handshake ALU with iterative multiply; ALU_CARRY_EN adds carry_out
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [OP_W-1:0]  opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             is_zero
`ifdef ALU_CARRY_EN
  ,
  output logic             carry_out
`endif
);
  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  alu_op_e          w_op;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic             r_mul_zero;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_mul_product;

`ifdef ALU_CARRY_EN
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_mul_ovf;
  assign w_sum = {1'b0, rs1} + {1'b0, rs2};
`else
  logic [WIDTH-1:0] w_sum;
  logic             w_unused_mul_ovf;
  assign w_sum = rs1 + rs2;
`endif

  assign w_op        = alu_op_e'(opcode);
  // A held result blocks issue; a draining one lets the next op in the same cycle.
  assign in_ready    = (r_state == IDLE) && (!out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && is_multi_cycle(w_op);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (w_mul_start),
    .i_a        (rs1),
    .i_b        (rs2),
    .o_done     (w_mul_done),
    .o_product  (w_mul_product),
`ifdef ALU_CARRY_EN
    .o_overflow (w_mul_ovf)
`else
    .o_overflow (w_unused_mul_ovf)
`endif
  );

  // Single-cycle result selection.
  always_comb begin
    w_result = rs1;
`ifdef ALU_CARRY_EN
    w_carry  = 1'b0;
`endif
    case (w_op)
      OP_PASS_A0, OP_PASS_A1: w_result = rs1;
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
`ifdef ALU_CARRY_EN
        w_carry  = w_sum[WIDTH];
`endif
      end
      OP_AND:    w_result = rs1 & rs2;
      OP_XOR:    w_result = rs1 ^ rs2;
      OP_PASS_B: w_result = rs2;
      OP_SHR:    w_result = rs1 >> rs2[SHAMT_W-1:0];
      default:   w_result = rs1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: IDLE leaves only for a multiply, MUL returns on the final step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_mul_start) w_state_next = MUL;
      MUL:     if (w_mul_done)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output register: load on single-cycle accept or multiply completion, clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      rd         <= '0;
      is_zero    <= 1'b0;
      r_mul_zero <= 1'b0;
`ifdef ALU_CARRY_EN
      carry_out  <= 1'b0;
`endif
    end else begin
      if (w_mul_start) begin
        r_mul_zero <= ~|rs1;
      end
      if (w_accept && !w_mul_start) begin
        out_valid <= 1'b1;
        rd        <= w_result;
        is_zero   <= ~|rs1;
`ifdef ALU_CARRY_EN
        carry_out <= w_carry;
`endif
      end else if (w_mul_done) begin
        out_valid <= 1'b1;
        rd        <= w_mul_product;
        is_zero   <= r_mul_zero;
`ifdef ALU_CARRY_EN
        carry_out <= w_mul_ovf;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed scoreboard bench for alu_pipe
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rd;
  logic         is_zero;
`ifdef ALU_CARRY_EN
  logic         carry_out;
`endif

  typedef struct {
    logic [W-1:0] rd;
    logic         zero;
    logic         carry;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .is_zero   (is_zero)
`ifdef ALU_CARRY_EN
    ,
    .carry_out (carry_out)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t             e;
    logic [2*W-1:0]   wide;
    logic [$clog2(W)-1:0] sh;
    e.rd      = '0;
    e.carry   = 1'b0;
    e.zero    = (a == '0);
    e.acc_cyc = 0;
    e.lat     = 0;
    wide      = '0;
    sh        = b[$clog2(W)-1:0];
    case (op)
      3'b000, 3'b001: e.rd = a;
      3'b010: begin
        wide    = a + b;
        e.rd    = wide[W-1:0];
        e.carry = wide[W];
      end
      3'b011: e.rd = a & b;
      3'b100: e.rd = a ^ b;
      3'b101: e.rd = b;
      3'b110: begin
        wide    = a * b;
        e.rd    = wide[W-1:0];
        e.carry = |wide[2*W-1:W];
      end
      default: e.rd = a >> sh;
    endcase
    return e;
  endfunction

  // Drive one op, wait (bounded) for in_ready, record expectation at the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input bit push, output int waited);
    exp_t e;
    opcode   = op;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("issue_ready", in_ready, 1);
    @(posedge clk);
    if (push) begin
      e         = model(op, a, b);
      e.acc_cyc = cyc;
      e.lat     = lat;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  // Compare every consumed result against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_asrt++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_result: observed rd %0h expected no result", rd);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rd", rd, e.rd);
        check("is_zero", is_zero, e.zero);
`ifdef ALU_CARRY_EN
        check("carry_out", carry_out, e.carry);
`endif
        if (e.lat != 0) check("latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    rs1       = '0;
    rs2       = '0;
    opcode    = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd", rd, 0);
    check("rst_is_zero", is_zero, 0);
`ifdef ALU_CARRY_EN
    check("rst_carry", carry_out, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    issue(OP_ADD,     8'hF0, 8'h20, 1, 1, w);
    issue(OP_XOR,     8'hAA, 8'hFF, 1, 1, w);
    check("b2b_no_stall", w, 0);
    issue(OP_AND,     8'h3C, 8'h0F, 1, 1, w);
    issue(OP_PASS_A0, 8'h5A, 8'hC3, 1, 1, w);
    issue(OP_PASS_A1, 8'hA5, 8'h3C, 1, 1, w);
    issue(OP_ADD,     8'h01, 8'h02, 1, 1, w);
    issue(OP_SHR,     8'hB6, 8'h00, 1, 1, w);
    issue(OP_SHR,     8'hB6, 8'h0B, 1, 1, w);
    check("b2b_no_stall_end", w, 0);
    repeat (2) @(posedge clk);
    #1;

    issue(OP_MUL, 8'd13, 8'd11, W + 1, 1, w);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("mul_in_ready_low", in_ready, 0);
      check("mul_out_valid_low", out_valid, 0);
    end
    @(negedge clk);
    check("mul_out_valid", out_valid, 1);
    @(posedge clk);
    #1;

    issue(OP_MUL, 8'hFF, 8'hFF, W + 1, 1, w);
    opcode   = OP_ADD;
    rs1      = 8'h01;
    rs2      = 8'h01;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    out_ready = 1'b0;
    issue(OP_SHR, 8'h80, 8'h03, 0, 1, w);
    opcode   = OP_ADD;
    rs1      = 8'h07;
    rs2      = 8'h07;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_rd", rd, 8'h10);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(OP_PASS_B, 8'h00, 8'h7E, 1, 1, w);
    check("bp_same_cycle_accept", w, 0);
    issue(OP_PASS_B, 8'h01, 8'h7E, 1, 1, w);
    repeat (2) @(posedge clk);
    #1;

    issue(OP_MUL, 8'hC8, 8'h03, 0, 0, w);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_rd", rd, 0);
    check("abort_is_zero", is_zero, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end
    check("abort_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    issue(OP_ADD, 8'h12, 8'h34, 1, 1, w);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
